// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_queue
// Purpose  : Writer-side front end of the integer register file. Accepts
//            results from the load unit and the ALU, keeps them in program
//            order in a small circular queue and drains one result per cycle
//            into registered register-file write outputs. Two combinational
//            lookup ports let operand fetch forward still-pending values.
// Ports    : clk, resetN (async, active-low)
//            memValid/memReady/memRd/memData   load result input
//            aluValid/aluReady/aluRd/aluData   ALU result input
//            writeRegister/writeData/regWrite  register file write port (reg)
//            lookupReg1/hit1/hitData1          forwarding query 1
//            lookupReg2/hit2/hitData2          forwarding query 2
//            count                             occupied queue entries
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  memValid,
    output logic                  memReady,
    input  logic [ADDR_WIDTH-1:0] memRd,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [ADDR_WIDTH-1:0] aluRd,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] lookupReg1,
    output logic                  hit1,
    output logic [DATA_WIDTH-1:0] hitData1,
    input  logic [ADDR_WIDTH-1:0] lookupReg2,
    output logic                  hit2,
    output logic [DATA_WIDTH-1:0] hitData2,
    output logic [CW-1:0]         count
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  regWrite_q, regWrite_d;
    logic [ADDR_WIDTH-1:0] writeRegister_q, writeRegister_d;
    logic [DATA_WIDTH-1:0] writeData_q, writeData_d;

    logic [CW-1:0]         free;
    logic                  mem_push;
    logic                  alu_push;
    logic                  pop;
    logic [PW-1:0]         alu_slot;

    always_comb begin
        // Credit is based on occupancy at cycle start; a same-cycle pop
        // does not free a slot for this cycle's accepts.
        free     = CW'(DEPTH) - count_q;
        memReady = (free >= CW'(1));
        // The ALU only gets the last free slot when the load unit is idle.
        aluReady = (free >= CW'(2)) || ((free >= CW'(1)) && !memValid);

        // Results to x0 are consumed but never stored.
        mem_push = memValid && memReady && (memRd != '0);
        alu_push = aluValid && aluReady && (aluRd != '0);
        pop      = (count_q != '0);

        rd_d     = rd_q;
        data_d   = data_q;
        // Load result is older, so it takes the tail slot first.
        alu_slot = tail_q + PW'(mem_push);
        if (mem_push) begin
            rd_d[tail_q]   = memRd;
            data_d[tail_q] = memData;
        end
        if (alu_push) begin
            rd_d[alu_slot]   = aluRd;
            data_d[alu_slot] = aluData;
        end

        tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

        regWrite_d      = pop;
        writeRegister_d = pop ? rd_q[head_q]   : writeRegister_q;
        writeData_d     = pop ? data_q[head_q] : writeData_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            regWrite_q      <= 1'b0;
            writeRegister_q <= '0;
            writeData_q     <= '0;
        end else begin
            rd_q            <= rd_d;
            data_q          <= data_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            regWrite_q      <= regWrite_d;
            writeRegister_q <= writeRegister_d;
            writeData_q     <= writeData_d;
        end
    end

    // Scan oldest to youngest so later matches override earlier ones:
    // output stage first, then queue from head toward tail.
    function automatic void lookup(
        input  logic [ADDR_WIDTH-1:0] key,
        output logic                  hit,
        output logic [DATA_WIDTH-1:0] data
    );
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        if (regWrite_q && (writeRegister_q == key)) begin
            hit  = 1'b1;
            data = writeData_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (rd_q[idx] == key)) begin
                hit  = 1'b1;
                data = data_q[idx];
            end
        end
        if (key == '0) begin
            hit  = 1'b0;
            data = '0;
        end
    endfunction

    always_comb begin
        hit1     = 1'b0;
        hitData1 = '0;
        hit2     = 1'b0;
        hitData2 = '0;
        lookup(lookupReg1, hit1, hitData1);
        lookup(lookupReg2, hit2, hitData2);
    end

    assign regWrite      = regWrite_q;
    assign writeRegister = writeRegister_q;
    assign writeData     = writeData_q;
    assign count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_queue
// Purpose  : Directed self-checking bench for regfile_writeback_queue
//            (DEPTH=4, DATA_WIDTH=32, ADDR_WIDTH=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        resetN;
    logic        memValid, aluValid;
    logic        memReady, aluReady;
    logic [4:0]  memRd, aluRd;
    logic [31:0] memData, aluData;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [4:0]  lookupReg1, lookupReg2;
    logic        hit1, hit2;
    logic [31:0] hitData1, hitData2;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    regfile_writeback_queue #(
        .DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .resetN(resetN),
        .memValid(memValid), .memReady(memReady), .memRd(memRd), .memData(memData),
        .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
        .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
        .lookupReg1(lookupReg1), .hit1(hit1), .hitData1(hitData1),
        .lookupReg2(lookupReg2), .hit2(hit2), .hitData2(hitData2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; checks after this see post-edge state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        memValid = 1'b0; aluValid = 1'b0;
        memRd = '0; aluRd = '0; memData = '0; aluData = '0;
        lookupReg1 = '0; lookupReg2 = '0;
        #23;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_count", count, 0);
        chk("rst_wreg", writeRegister, 0);
        chk("rst_wdata", writeData, 0);
        chk("rst_memReady", memReady, 1);
        chk("rst_aluReady", aluReady, 1);
        resetN = 1'b1;
        tick();

        // ---- Test 1: single ALU result, latency and lookup window ----
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF; lookupReg1 = 5'd5;
        chk("t1_aluReady", aluReady, 1);
        chk("t1_no_samecycle_hit", hit1, 0);
        tick(); // edge E
        aluValid = 1'b0;
        chk("t1_E_count", count, 1);
        chk("t1_E_regWrite", regWrite, 0);
        chk("t1_E_hit", hit1, 1);
        chk("t1_E_hitData", hitData1, 32'hDEADBEEF);
        tick(); // E+1
        chk("t1_E1_regWrite", regWrite, 1);
        chk("t1_E1_wreg", writeRegister, 5);
        chk("t1_E1_wdata", writeData, 32'hDEADBEEF);
        chk("t1_E1_count", count, 0);
        chk("t1_E1_hit", hit1, 1);
        tick(); // E+2
        chk("t1_E2_regWrite", regWrite, 0);
        chk("t1_E2_hit", hit1, 0);
        chk("t1_E2_hitData", hitData1, 0);
        chk("t1_E2_wreg_hold", writeRegister, 5);

        // ---- Test 2: same-cycle mem+alu to same rd ----
        memValid = 1'b1; memRd = 5'd3; memData = 32'd11;
        aluValid = 1'b1; aluRd = 5'd3; aluData = 32'd22;
        lookupReg2 = 5'd3;
        chk("t2_memReady", memReady, 1);
        chk("t2_aluReady", aluReady, 1);
        tick();
        memValid = 1'b0; aluValid = 1'b0;
        chk("t2_count2", count, 2);
        chk("t2_hit_q", hit2, 1);
        chk("t2_hitData_q", hitData2, 22);
        tick();
        chk("t2_w1_regWrite", regWrite, 1);
        chk("t2_w1_wreg", writeRegister, 3);
        chk("t2_w1_wdata", writeData, 11);
        chk("t2_w1_hitData", hitData2, 22);
        tick();
        chk("t2_w2_regWrite", regWrite, 1);
        chk("t2_w2_wdata", writeData, 22);
        chk("t2_w2_hitData", hitData2, 22);
        tick();
        chk("t2_done_regWrite", regWrite, 0);
        chk("t2_done_hit", hit2, 0);

        // ---- Test 3: rd==0 is consumed but dropped ----
        aluValid = 1'b1; aluRd = 5'd0; aluData = 32'hFFFFFFFF;
        chk("t3_aluReady", aluReady, 1);
        tick();
        aluValid = 1'b0;
        chk("t3_count", count, 0);
        chk("t3_regWrite_a", regWrite, 0);
        tick();
        chk("t3_regWrite_b", regWrite, 0);

        // ---- Test 4: both sources every cycle, backpressure and order ----
        memValid = 1'b1; memRd = 5'd1; memData = 32'h101;
        aluValid = 1'b1; aluRd = 5'd2; aluData = 32'h102;
        lookupReg1 = 5'd2;
        tick();
        chk("t4_c0_count", count, 2);
        chk("t4_c0_hitData", hitData1, 32'h102);
        memRd = 5'd3; memData = 32'h103; aluRd = 5'd4; aluData = 32'h104;
        chk("t4_c1_aluReady", aluReady, 1);
        tick();
        chk("t4_c1_count", count, 3);
        chk("t4_c1_wreg", writeRegister, 1);
        memRd = 5'd5; memData = 32'h105; aluRd = 5'd6; aluData = 32'h106;
        chk("t4_c2_memReady", memReady, 1);
        chk("t4_c2_aluReady", aluReady, 0);
        tick();
        chk("t4_c2_count", count, 3);
        chk("t4_c2_wreg", writeRegister, 2);
        memRd = 5'd7; memData = 32'h107;
        chk("t4_c3_aluReady", aluReady, 0);
        tick();
        memValid = 1'b0; aluValid = 1'b0;
        chk("t4_c3_count", count, 3);
        chk("t4_c3_wreg", writeRegister, 3);
        chk("t4_c3_wdata", writeData, 32'h103);
        tick();
        chk("t4_d4_wreg", writeRegister, 4);
        chk("t4_d4_wdata", writeData, 32'h104);
        tick();
        chk("t4_d5_wreg", writeRegister, 5);
        tick();
        chk("t4_d7_wreg", writeRegister, 7);
        chk("t4_d7_wdata", writeData, 32'h107);
        chk("t4_d7_regWrite", regWrite, 1);
        chk("t4_d7_count", count, 0);
        tick();
        chk("t4_idle_regWrite", regWrite, 0);

        // ---- Test 5: async reset with entries pending ----
        memValid = 1'b1; memRd = 5'd8;  memData = 32'h208;
        aluValid = 1'b1; aluRd = 5'd9;  aluData = 32'h209;
        tick();
        memRd = 5'd10; memData = 32'h20A; aluRd = 5'd11; aluData = 32'h20B;
        tick();
        memValid = 1'b0; aluValid = 1'b0;
        chk("t5_pre_count", count, 3);
        chk("t5_pre_regWrite", regWrite, 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("t5_rst_regWrite", regWrite, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_wreg", writeRegister, 0);
        tick();
        resetN = 1'b1;
        tick();
        chk("t5_post1_regWrite", regWrite, 0);
        tick();
        chk("t5_post2_regWrite", regWrite, 0);
        chk("t5_post2_count", count, 0);

        // ---- Test 6: empty-queue lookups, x0 query ----
        lookupReg1 = 5'd0; lookupReg2 = 5'd7;
        #1;
        chk("t6_hit1", hit1, 0);
        chk("t6_hitData1", hitData1, 0);
        chk("t6_hit2", hit2, 0);
        chk("t6_hitData2", hitData2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
